dm_access: RTL and testbench
============================

# dm_access

Data-memory access unit for the pipelined MIPS core, sitting between the MEM stage and the data-memory bus. It packs narrow store data into word-wide, byte-enabled bus writes, and extracts and sign- or zero-extends byte and halfword fields from word-wide bus reads. It runs a request/response handshake with a variable-latency memory and includes alignment checking and a response watchdog.

## Interface
Parameters:
- TIMEOUT, 15: max cycles in WAIT before a timeout response (1..15, 4-bit counter).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  high only in IDLE; transfer occurs when req_valid && req_ready.
- req_op  in  4  NOP=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (low bits used for SH/SB).
- mem_en  out  1  one-cycle bus strobe.
- mem_we  out  4  byte write enables; 4'b0000 for loads.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_wdata  out  32  replicated store data.
- mem_rvalid  in  1  bus completion: read data valid, or write acknowledged.
- mem_rdata  in  32  bus read word.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load result; 0 for stores and for errors.
- resp_exc  out  2  0=none, 1=misaligned, 2=timeout, 3=illegal op.

## Operation
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On transfer, latch op, addr and wdata.
  - Aligned legal op: go to ISSUE.
  - Misaligned (LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0): go to RESP with exc=1, no bus access.
  - op 0 or >8: go to RESP with exc=3.
- ISSUE: mem_en=1 for exactly this cycle; go to WAIT and clear the counter.
- WAIT, when mem_rvalid=1: capture the result and go to RESP with exc=0.
- WAIT, otherwise: increment the counter. When the counter reaches TIMEOUT, go to RESP with exc=2.
- RESP: resp_valid=1, with data and exc held stable. On resp_ready, go to IDLE.
- mem_rvalid is ignored outside WAIT.
- Store packing (k=addr[1:0]):
  - SB: we=4'b0001<<k, wdata={4{d[7:0]}}.
  - SH: we=addr[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}.
  - SW: we=4'b1111, wdata=d.
- Load extraction:
  - LB/LBU: byte k of mem_rdata, sign- or zero-extended.
  - LH/LHU: half addr[1] of mem_rdata, sign- or zero-extended.
  - LW: the full word.
- mem_we, mem_addr and mem_wdata are valid only while mem_en=1; they are 0 otherwise.

## Timing
- Reset values: state=IDLE, req_ready=1, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_exc=0, counter=0.
- Latency, aligned access: transfer in cycle T, mem_en in T+1, earliest mem_rvalid in T+2, resp_valid from T+3.
- Minimum repeat rate is 4 cycles per access.
- Latency, error path: resp_valid from T+1.
- resp_valid and resp_ready high in the same cycle: accepted. req_ready rises the next cycle. No bypass from RESP to ISSUE.
- mem_rvalid in the same WAIT cycle that the counter hits TIMEOUT: data wins, exc=0.
- Reset mid-operation: state forced to IDLE the next edge. Any late mem_rvalid is ignored.

## Structure
- Package dm_pkg holds:
  - op codes (4-bit);
  - exc codes (2-bit);
  - state encoding (2-bit: IDLE=0, ISSUE=1, WAIT=2, RESP=3).
- Sub-module load_ext is combinational (op, addr[1:0], word -> 32-bit result) and is instantiated in the WAIT capture path.
- Store packing and the FSM live in the top module.

## Test plan
- SB, addr=0x1003, wdata=0x000000A5, mem_rvalid 2 cycles after mem_en -> mem_we=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000; resp exc=0, rdata=0.
- LB addr=0x2001, mem_rdata=0x12348056 -> rdata=0x00000080 for LBU; for LB at addr 0x2002 -> 0x00000034.
- LH addr=0x2002, mem_rdata=0x80001234 -> rdata=0xFFFF8000; LHU -> 0x00008000.
- LW addr=0x3002 -> no mem_en; resp_valid the cycle after transfer, exc=1. op=9 -> exc=3.
- mem_rvalid never arrives, TIMEOUT=15 -> resp exc=2 after 15 WAIT cycles. A variant with mem_rvalid in the 15th WAIT cycle -> exc=0 with data.
- reset asserted while in WAIT, with mem_rvalid pulsed the next cycle -> block in IDLE, req_ready=1, resp_valid stays 0. resp_ready held low for 5 cycles -> resp held stable.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access unit: op codes, exception codes, FSM states.
package dm_pkg;

  typedef enum logic [3:0] {
    OpNop = 4'd0,
    OpLw  = 4'd1,
    OpLh  = 4'd2,
    OpLhu = 4'd3,
    OpLb  = 4'd4,
    OpLbu = 4'd5,
    OpSw  = 4'd6,
    OpSh  = 4'd7,
    OpSb  = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ExcNone     = 2'd0,
    ExcMisalign = 2'd1,
    ExcTimeout  = 2'd2,
    ExcIllegal  = 2'd3
  } exc_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  function automatic logic op_legal(logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic logic op_is_store(logic [3:0] op);
    return (op == OpSw) || (op == OpSh) || (op == OpSb);
  endfunction

  // Word ops need addr[1:0]==0, halfword ops need addr[0]==0; byte ops never fault.
  function automatic logic op_misaligned(logic [3:0] op, logic [1:0] a);
    logic mis;
    mis = 1'b0;
    case (op)
      OpLw, OpSw:        mis = (a != 2'b00);
      OpLh, OpLhu, OpSh: mis = a[0];
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational load extraction: selects the byte/half of a bus word and extends it.
module load_ext
  import dm_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Field select followed by sign/zero extension according to op.
  always_comb begin
    byte_sel = 8'h00;
    unique case (addr_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    result_o = 32'h0;
    case (op_i)
      OpLb:    result_o = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   result_o = {24'h0, byte_sel};
      OpLh:    result_o = {{16{half_sel[15]}}, half_sel};
      OpLhu:   result_o = {16'h0, half_sel};
      OpLw:    result_o = word_i;
      default: result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dm_access.sv
// Data-memory access unit: request/response FSM, store packing, load extraction, watchdog.
module dm_access
  import dm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc
);

  localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  exc_e        exc_q, exc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] load_result;

  load_ext u_load_ext (
    .op_i     (op_q),
    .addr_i   (addr_q[1:0]),
    .word_i   (mem_rdata),
    .result_o (load_result)
  );

  // State and request/response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      exc_q   <= ExcNone;
      cnt_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept, classify, issue, wait with watchdog, hold response.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          if (!op_legal(req_op)) begin
            exc_d   = ExcIllegal;
            state_d = StResp;
          end else if (op_misaligned(req_op, req_addr[1:0])) begin
            exc_d   = ExcMisalign;
            state_d = StResp;
          end else begin
            exc_d   = ExcNone;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = 4'h0;
        state_d = StWait;
      end
      StWait: begin
        // A completion in the same cycle as the watchdog expiry takes priority.
        if (mem_rvalid) begin
          rdata_d = op_is_store(op_q) ? 32'h0 : load_result;
          exc_d   = ExcNone;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == TimeoutCnt) begin
            rdata_d = 32'h0;
            exc_d   = ExcTimeout;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus strobe and store packing; bus fields are zero whenever mem_en is low.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (state_q == StIssue) begin
      mem_en   = 1'b1;
      mem_addr = {addr_q[31:2], 2'b00};
      case (op_q)
        OpSb: begin
          mem_we    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        OpSh: begin
          mem_we    = addr_q[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{wdata_q[15:0]}};
        end
        OpSw: begin
          mem_we    = 4'b1111;
          mem_wdata = wdata_q;
        end
        default: begin
          mem_we    = 4'b0000;
          mem_wdata = 32'h0;
        end
      endcase
    end
  end

  // Handshake outputs derive from the registered state only.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_rdata = rdata_q;
    resp_exc   = exc_q;
  end

endmodule

// File: tb/tb_dm_access.sv
// Directed self-checking bench for dm_access.
module tb_dm_access;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;

  int n_tests = 0;
  int n_fail  = 0;

  dm_access #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_exc   (resp_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns just after the transfer edge.
  task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  // Accept the pending response and confirm the unit is back in IDLE.
  task automatic accept(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, "_ready_back"}, {31'h0, req_ready}, 32'h1);
    check({tag, "_resp_drop"}, {31'h0, resp_valid}, 32'h0);
  endtask

  // Aligned load: transfer, ISSUE, one WAIT cycle, then completion with the given word.
  task automatic load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] word, input logic [31:0] exp);
    send(op, addr, 32'h0);
    check({tag, "_en"}, {31'h0, mem_en}, 32'h1);
    check({tag, "_we"}, {28'h0, mem_we}, 32'h0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    step();
    mem_rvalid = 1'b0;
    check({tag, "_rvalid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, "_rdata"}, resp_rdata, exp);
    check({tag, "_exc"}, {30'h0, resp_exc}, 32'h0);
    accept(tag);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 4'h0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    resp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_mem_en", {31'h0, mem_en}, 32'h0);
    check("rst_mem_we", {28'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_exc", {30'h0, resp_exc}, 32'h0);

    // SB at 0x1003, completion 2 cycles after mem_en
    send(4'd8, 32'h0000_1003, 32'h0000_00A5);
    check("sb_en", {31'h0, mem_en}, 32'h1);
    check("sb_we", {28'h0, mem_we}, 32'h8);
    check("sb_addr", mem_addr, 32'h0000_1000);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_busy", {31'h0, req_ready}, 32'h0);
    step();
    check("sb_en_one_cycle", {31'h0, mem_en}, 32'h0);
    check("sb_we_idle", {28'h0, mem_we}, 32'h0);
    check("sb_addr_idle", mem_addr, 32'h0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    check("sb_resp_valid", {31'h0, resp_valid}, 32'h1);
    check("sb_resp_exc", {30'h0, resp_exc}, 32'h0);
    check("sb_resp_rdata", resp_rdata, 32'h0);
    accept("sb");

    // Other store packings
    send(4'd7, 32'h0000_0002, 32'h1234_5678);
    check("sh_hi_we", {28'h0, mem_we}, 32'hC);
    check("sh_hi_wdata", mem_wdata, 32'h5678_5678);
    step();
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    accept("sh_hi");
    send(4'd7, 32'h0000_0040, 32'h0000_BEEF);
    check("sh_lo_we", {28'h0, mem_we}, 32'h3);
    check("sh_lo_addr", mem_addr, 32'h0000_0040);
    step();
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    accept("sh_lo");
    send(4'd6, 32'h0000_0104, 32'hCAFE_F00D);
    check("sw_we", {28'h0, mem_we}, 32'hF);
    check("sw_wdata", mem_wdata, 32'hCAFE_F00D);
    step();
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    accept("sw");
    send(4'd8, 32'h0000_0000, 32'hFFFF_FF3C);
    check("sb0_we", {28'h0, mem_we}, 32'h1);
    check("sb0_wdata", mem_wdata, 32'h3C3C_3C3C);
    step();
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    accept("sb0");

    // Load extraction
    load("lbu_2001", 4'd5, 32'h0000_2001, 32'h1234_8056, 32'h0000_0080);
    load("lb_2001", 4'd4, 32'h0000_2001, 32'h1234_8056, 32'hFFFF_FF80);
    load("lb_2002", 4'd4, 32'h0000_2002, 32'h1234_8056, 32'h0000_0034);
    load("lh_2002", 4'd2, 32'h0000_2002, 32'h8000_1234, 32'hFFFF_8000);
    load("lhu_2002", 4'd3, 32'h0000_2002, 32'h8000_1234, 32'h0000_8000);
    load("lh_2000", 4'd2, 32'h0000_2000, 32'h8000_1234, 32'h0000_1234);
    load("lw_3000", 4'd1, 32'h0000_3000, 32'h89AB_CDEF, 32'h89AB_CDEF);

    // Error paths: response the cycle after transfer, no bus access
    send(4'd1, 32'h0000_3002, 32'h0);
    check("mis_lw_en", {31'h0, mem_en}, 32'h0);
    check("mis_lw_valid", {31'h0, resp_valid}, 32'h1);
    check("mis_lw_exc", {30'h0, resp_exc}, 32'h1);
    check("mis_lw_rdata", resp_rdata, 32'h0);
    accept("mis_lw");
    send(4'd7, 32'h0000_3001, 32'h0);
    check("mis_sh_exc", {30'h0, resp_exc}, 32'h1);
    check("mis_sh_en", {31'h0, mem_en}, 32'h0);
    accept("mis_sh");
    send(4'd9, 32'h0000_3000, 32'h0);
    check("ill9_valid", {31'h0, resp_valid}, 32'h1);
    check("ill9_exc", {30'h0, resp_exc}, 32'h3);
    check("ill9_en", {31'h0, mem_en}, 32'h0);
    accept("ill9");
    send(4'd0, 32'h0000_3000, 32'h0);
    check("ill0_exc", {30'h0, resp_exc}, 32'h3);
    accept("ill0");

    // Watchdog: no completion, response after exactly 15 WAIT cycles
    send(4'd1, 32'h0000_4000, 32'h0);
    step();
    n = 0;
    while (!resp_valid && n < 40) begin
      n++;
      step();
    end
    check("to_wait_cycles", 32'(n), 32'd15);
    check("to_exc", {30'h0, resp_exc}, 32'h2);
    check("to_rdata", resp_rdata, 32'h0);
    accept("to");

    // Completion in the 15th WAIT cycle beats the watchdog
    send(4'd1, 32'h0000_4000, 32'h0);
    step();
    repeat (14) step();
    check("race_still_wait", {31'h0, resp_valid}, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    step();
    mem_rvalid = 1'b0;
    check("race_valid", {31'h0, resp_valid}, 32'h1);
    check("race_exc", {30'h0, resp_exc}, 32'h0);
    check("race_rdata", resp_rdata, 32'h5555_AAAA);
    accept("race");

    // Reset during WAIT, late completion ignored
    send(4'd1, 32'h0000_5000, 32'h0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rw_ready", {31'h0, req_ready}, 32'h1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    step();
    mem_rvalid = 1'b0;
    check("rw_ready2", {31'h0, req_ready}, 32'h1);
    check("rw_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rw_mem_en", {31'h0, mem_en}, 32'h0);
    step();
    check("rw_resp_valid2", {31'h0, resp_valid}, 32'h0);

    // Response held stable while resp_ready is low
    send(4'd2, 32'h0000_6002, 32'h0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hF00F_0000;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'h0, resp_valid}, 32'h1);
      check("hold_rdata", resp_rdata, 32'hFFFF_F00F);
      check("hold_exc", {30'h0, resp_exc}, 32'h0);
      check("hold_not_ready", {31'h0, req_ready}, 32'h0);
      step();
    end
    accept("hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
